// File: rtl/instruction_decode_pkg.sv
// Shared decode definitions: opcode map, immediate-extension modes, ID/EX register layout.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package instruction_decode_pkg;

  localparam int DATA_W = 32;
  localparam int REG_N  = 32;
  localparam int ADDR_W = 5;

  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_LI    = 6'b111000;
  localparam logic [5:0] OP_LUI   = 6'b111001;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_ANDI  = 6'b110010;
  localparam logic [5:0] OP_ORI   = 6'b110011;
  localparam logic [5:0] OP_B     = 6'b111111;
  localparam logic [5:0] OP_BEQ   = 6'b000000;
  localparam logic [5:0] OP_BNE   = 6'b000001;
  localparam logic [5:0] OP_LB    = 6'b000011;
  localparam logic [5:0] OP_LW    = 6'b001111;
  localparam logic [5:0] OP_SB    = 6'b000111;
  localparam logic [5:0] OP_SW    = 6'b011111;

  // IMM_NONE covers R-type and unknown opcodes: immediate forced to zero.
  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_SEXT,
    IMM_ZERO,
    IMM_LUI,
    IMM_BR
  } imm_mode_e;

  typedef struct packed {
    imm_mode_e mode;
    logic      legal;
  } op_class_t;

  // ID/EX pipeline register; src_a/src_b are kept so stalled operands can be refreshed.
  typedef struct packed {
    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;
    logic [DATA_W-1:0] immed;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] src_a;
    logic [ADDR_W-1:0] src_b;
    logic [5:0]        opcode;
    logic [5:0]        func;
    logic              valid;
    logic              illegal;
  } idex_t;

  function automatic op_class_t classify(input logic [5:0] op);
    op_class_t c;
    c.legal = 1'b1;
    c.mode  = IMM_NONE;
    case (op)
      OP_RTYPE:                                c.mode = IMM_NONE;
      OP_LI, OP_ADDI, OP_LB, OP_LW, OP_SB, OP_SW: c.mode = IMM_SEXT;
      OP_ANDI, OP_ORI:                         c.mode = IMM_ZERO;
      OP_LUI:                                  c.mode = IMM_LUI;
      OP_B, OP_BEQ, OP_BNE:                    c.mode = IMM_BR;
      default: begin
        c.legal = 1'b0;
        c.mode  = IMM_NONE;
      end
    endcase
    return c;
  endfunction

  // Branch offsets are word offsets; the shift drops the top bits (mod 2^32).
  function automatic logic [DATA_W-1:0] extend_imm(input imm_mode_e mode, input logic [15:0] imm);
    logic [DATA_W-1:0] r;
    case (mode)
      IMM_SEXT: r = {{16{imm[15]}}, imm};
      IMM_ZERO: r = {16'h0000, imm};
      IMM_LUI:  r = {imm, 16'h0000};
      IMM_BR:   r = {{14{imm[15]}}, imm, 2'b00};
      default:  r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instruction_decode_register_file.sv
// 32x32 register file: two async read ports, one sync write port, R0 reads as zero.
// Latency: reads combinational with write-first bypass; writes land on the next edge.
// Backpressure: none; writes are never blocked by pipeline stall or flush.
module instruction_decode_register_file
  import instruction_decode_pkg::*;
#(
  parameter int RF_DATA_W = DATA_W,
  parameter int RF_REG_N  = REG_N,
  parameter int RF_ADDR_W = ADDR_W
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 wr_en,
  input  logic [RF_ADDR_W-1:0] wr_addr,
  input  logic [RF_DATA_W-1:0] wr_dat,
  input  logic [RF_ADDR_W-1:0] rd_a_addr,
  output logic [RF_DATA_W-1:0] rd_a_dat,
  input  logic [RF_ADDR_W-1:0] rd_b_addr,
  output logic [RF_DATA_W-1:0] rd_b_dat
);

  logic [RF_DATA_W-1:0] regs_q [RF_REG_N];
  logic [RF_DATA_W-1:0] regs_d [RF_REG_N];
  logic                 wr_hit;

  assign wr_hit = wr_en && (wr_addr != '0);

  // Next register state: only a non-zero address is ever written.
  always_comb begin
    for (int i = 0; i < RF_REG_N; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_hit) begin
      regs_d[wr_addr] = wr_dat;
    end
  end

  // Storage update; reset clears every entry.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < RF_REG_N; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < RF_REG_N; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read ports: R0 is zero, a same-cycle write to the read address is bypassed.
  always_comb begin
    if (rd_a_addr == '0)                    rd_a_dat = '0;
    else if (wr_hit && wr_addr == rd_a_addr) rd_a_dat = wr_dat;
    else                                     rd_a_dat = regs_q[rd_a_addr];

    if (rd_b_addr == '0)                    rd_b_dat = '0;
    else if (wr_hit && wr_addr == rd_b_addr) rd_b_dat = wr_dat;
    else                                     rd_b_dat = regs_q[rd_b_addr];
  end

endmodule

// File: rtl/instruction_decode.sv
// ID stage: decodes Instr, reads two operands, extends the immediate into the ID/EX register.
// Latency: 1 cycle from Instr sampled to outputs.
// Backpressure: Stall holds ID/EX (operands refreshed by write-back), Flush inserts a bubble.
module instruction_decode
  import instruction_decode_pkg::*;
#(
  parameter int P_DATA_W = DATA_W,
  parameter int P_REG_N  = REG_N,
  parameter int P_ADDR_W = ADDR_W
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [31:0]         Instr,
  input  logic                In_valid,
  input  logic                Stall,
  input  logic                Flush,
  input  logic                RF_WrEn,
  input  logic [P_ADDR_W-1:0] RF_Awr,
  input  logic [P_DATA_W-1:0] RF_WrData,
  output logic [P_DATA_W-1:0] RF_A,
  output logic [P_DATA_W-1:0] RF_B,
  output logic [P_DATA_W-1:0] Immed,
  output logic [P_ADDR_W-1:0] Rd_addr,
  output logic [5:0]          Opcode,
  output logic [5:0]          Func,
  output logic                Out_valid,
  output logic                Illegal
);

  logic [5:0]          opcode;
  logic [P_ADDR_W-1:0] src_a;
  logic [P_ADDR_W-1:0] src_b;
  logic [P_DATA_W-1:0] rd_a_dat;
  logic [P_DATA_W-1:0] rd_b_dat;
  op_class_t           cls;
  idex_t               dec;
  idex_t               idex_d;
  idex_t               idex_q;
  logic                wr_hit;

  assign opcode = Instr[31:26];
  assign src_a  = Instr[25:21];
  assign src_b  = (opcode == OP_RTYPE) ? Instr[15:11] : Instr[20:16];
  assign wr_hit = RF_WrEn && (RF_Awr != '0);

  instruction_decode_register_file #(
    .RF_DATA_W (P_DATA_W),
    .RF_REG_N  (P_REG_N),
    .RF_ADDR_W (P_ADDR_W)
  ) u_rf (
    .Clk       (Clk),
    .Reset     (Reset),
    .wr_en     (RF_WrEn),
    .wr_addr   (RF_Awr),
    .wr_dat    (RF_WrData),
    .rd_a_addr (src_a),
    .rd_a_dat  (rd_a_dat),
    .rd_b_addr (src_b),
    .rd_b_dat  (rd_b_dat)
  );

  // Decode of the incoming instruction; a bubble decodes to all zeros.
  always_comb begin
    cls = classify(opcode);
    dec = '0;
    if (In_valid) begin
      dec.rf_a    = rd_a_dat;
      dec.rf_b    = rd_b_dat;
      dec.immed   = extend_imm(cls.mode, Instr[15:0]);
      dec.rd_addr = Instr[20:16];
      dec.src_a   = src_a;
      dec.src_b   = src_b;
      dec.opcode  = opcode;
      dec.func    = Instr[5:0];
      dec.valid   = 1'b1;
      dec.illegal = !cls.legal;
    end
  end

  // Next ID/EX contents: Flush beats Stall beats load; held operands track write-back.
  always_comb begin
    idex_d = idex_q;
    if (Flush) begin
      idex_d = '0;
    end else if (Stall) begin
      if (wr_hit && RF_Awr == idex_q.src_a) idex_d.rf_a = RF_WrData;
      if (wr_hit && RF_Awr == idex_q.src_b) idex_d.rf_b = RF_WrData;
    end else begin
      idex_d = dec;
    end
  end

  // ID/EX register; reset overrides every other control.
  always_ff @(posedge Clk) begin
    if (Reset) idex_q <= '0;
    else       idex_q <= idex_d;
  end

  assign RF_A      = idex_q.rf_a;
  assign RF_B      = idex_q.rf_b;
  assign Immed     = idex_q.immed;
  assign Rd_addr   = idex_q.rd_addr;
  assign Opcode    = idex_q.opcode;
  assign Func      = idex_q.func;
  assign Out_valid = idex_q.valid;
  assign Illegal   = idex_q.illegal;

endmodule
